// File: rtl/axi_traffic_manager_if.sv
// AXI manager-side bus types and the interface bundling one AW/W/B/AR/R port.
// The package carries the beat payload structs shared by the manager and its subordinate.
package axi_traffic_manager_pkg;
  localparam int ID_W   = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
  } axi_aw_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
  } axi_ar_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
  } axi_w_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } axi_b_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [1:0]        resp;
    logic [DATA_W-1:0] data;
  } axi_r_t;
endpackage

interface axi_traffic_manager_if;
  import axi_traffic_manager_pkg::*;

  axi_aw_t aw;
  logic    awvalid;
  logic    awready;
  axi_w_t  w;
  logic    wvalid;
  logic    wready;
  axi_b_t  b;
  logic    bvalid;
  logic    bready;
  axi_ar_t ar;
  logic    arvalid;
  logic    arready;
  axi_r_t  r;
  logic    rvalid;
  logic    rready;

  modport master (
    output aw, awvalid, input awready,
    output w, wvalid, input wready,
    input b, bvalid, output bready,
    output ar, arvalid, input arready,
    input r, rvalid, output rready
  );

  modport slave (
    input aw, awvalid, output awready,
    input w, wvalid, output wready,
    output b, bvalid, input bready,
    input ar, arvalid, output arready,
    output r, rvalid, input rready
  );
endinterface

// File: rtl/axi_traffic_manager.sv
// Per-CPU AXI manager: writes a pattern to its private window, reads it back,
// and counts completed pairs and detected errors.
module axi_traffic_manager
  import axi_traffic_manager_pkg::*;
#(
  parameter int unsigned       CPU_ID         = 0,
  parameter int unsigned       TRANSACTION_NB = 1000,
  parameter int unsigned       WINDOW_WORDS   = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = ADDR_W'(CPU_ID * WINDOW_WORDS * 8)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  axi_traffic_manager_if.master        axi_m,
  output logic                         o_done,
  output logic [31:0]                  o_txn_cnt,
  output logic [31:0]                  o_error_cnt
);

  localparam logic [ID_W-1:0] ID_VAL    = ID_W'(CPU_ID);
  localparam logic [31:0]     TXN_LIMIT = 32'(TRANSACTION_NB);
  localparam logic [31:0]     IDX_MASK  = 32'(WINDOW_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT_B,
    S_READ,
    S_WAIT_R,
    S_DONE
  } state_t;

  // The window index wraps, but the data keeps the full pair number so a
  // stale word left over from a previous lap never matches.
  function automatic logic [ADDR_W-1:0] pair_addr(input logic [31:0] idx);
    logic [31:0] off;
    off = (idx & IDX_MASK) << 3;
    return BASE_ADDR + off;
  endfunction

  function automatic logic [DATA_W-1:0] pair_data(input logic [31:0] idx);
    return {32'(CPU_ID), idx};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] n_q, n_d;
  logic [31:0] txn_q, txn_d;
  logic [31:0] err_q, err_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;
  axi_aw_t     aw_q, aw_d;
  axi_w_t      w_q, w_d;
  axi_ar_t     ar_q, ar_d;
  logic        launch;
  logic [31:0] launch_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      txn_q     <= '0;
      err_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      aw_q      <= '0;
      w_q       <= '0;
      ar_q      <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      txn_q     <= txn_d;
      err_q     <= err_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      aw_q      <= aw_d;
      w_q       <= w_d;
      ar_q      <= ar_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    txn_d      = txn_q;
    err_d      = err_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    aw_d       = aw_q;
    w_d        = w_q;
    ar_d       = ar_q;
    launch     = 1'b0;
    launch_idx = n_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (TRANSACTION_NB == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WRITE;
            launch  = 1'b1;
          end
        end
      end
      S_WRITE: begin
        // AW and W retire independently; leave only when both are gone.
        if (awvalid_q && axi_m.awready) awvalid_d = 1'b0;
        if (wvalid_q && axi_m.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (axi_m.bvalid) begin
          if (axi_m.b.resp != 2'b00 || axi_m.b.id != ID_VAL) err_d = sat_inc(err_q);
          state_d   = S_READ;
          arvalid_d = 1'b1;
          ar_d.id   = ID_VAL;
          ar_d.addr = pair_addr(n_q);
        end
      end
      S_READ: begin
        if (arvalid_q && axi_m.arready) begin
          arvalid_d = 1'b0;
          state_d   = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        if (axi_m.rvalid) begin
          if (axi_m.r.resp != 2'b00 || axi_m.r.id != ID_VAL ||
              axi_m.r.data != pair_data(n_q)) begin
            err_d = sat_inc(err_q);
          end
          txn_d = txn_q + 32'd1;
          n_d   = n_q + 32'd1;
          if (n_d == TXN_LIMIT) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_WRITE;
            launch     = 1'b1;
            launch_idx = n_d;
          end
        end
      end
      S_DONE: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (launch) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      aw_d.id   = ID_VAL;
      aw_d.addr = pair_addr(launch_idx);
      w_d.data  = pair_data(launch_idx);
    end
  end

  assign axi_m.aw      = aw_q;
  assign axi_m.awvalid = awvalid_q;
  assign axi_m.w       = w_q;
  assign axi_m.wvalid  = wvalid_q;
  assign axi_m.bready  = (state_q == S_WAIT_B);
  assign axi_m.ar      = ar_q;
  assign axi_m.arvalid = arvalid_q;
  assign axi_m.rready  = (state_q == S_WAIT_R);

  assign o_done      = (state_q == S_DONE);
  assign o_txn_cnt   = txn_q;
  assign o_error_cnt = err_q;

endmodule

// File: tb/tb_axi_traffic_manager.sv
// Bench for axi_traffic_manager: three managers with different CPU_ID/TRANSACTION_NB
// share one subordinate memory model, selected one at a time.
module tb_axi_traffic_manager;
  import axi_traffic_manager_pkg::*;

  localparam int NDUT = 3;
  localparam int HIST = 2048;

  function automatic int unsigned cid_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 0 : 5;
  endfunction

  function automatic int unsigned tnb_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 1026 : 8;
  endfunction

  // Reference rules: window of 1024 words of 8 bytes per CPU, data {cpu, pair}.
  function automatic logic [31:0] exp_addr(input int k, input int unsigned i);
    return 32'(cid_of(k) * 1024 * 8 + (i % 1024) * 8);
  endfunction

  function automatic logic [63:0] exp_data(input int k, input int unsigned i);
    return {32'(cid_of(k)), 32'(i)};
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NDUT-1:0] start;
  logic [1:0]      sel;

  logic [NDUT-1:0] awvalid_v, wvalid_v, arvalid_v, bready_v, rready_v, done_v;
  axi_aw_t         aw_v [NDUT];
  axi_w_t          w_v  [NDUT];
  axi_ar_t         ar_v [NDUT];
  logic [31:0]     txn_v [NDUT];
  logic [31:0]     err_v [NDUT];

  logic    s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  axi_b_t  s_b;
  axi_r_t  s_r;
  logic    f_aw, f_w, f_ar, rnd_mode, rnd_aw, rnd_w, rnd_ar;
  int      inj_b, inj_r;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    axi_traffic_manager_if bus ();
    axi_traffic_manager #(.CPU_ID(cid_of(g)), .TRANSACTION_NB(tnb_of(g))) u_dut (
      .clk(clk), .rst(rst), .i_start(start[g]), .axi_m(bus.master),
      .o_done(done_v[g]), .o_txn_cnt(txn_v[g]), .o_error_cnt(err_v[g])
    );
    assign awvalid_v[g] = bus.awvalid;
    assign wvalid_v[g]  = bus.wvalid;
    assign arvalid_v[g] = bus.arvalid;
    assign bready_v[g]  = bus.bready;
    assign rready_v[g]  = bus.rready;
    assign aw_v[g]      = bus.aw;
    assign w_v[g]       = bus.w;
    assign ar_v[g]      = bus.ar;
    assign bus.awready  = s_awready;
    assign bus.wready   = s_wready;
    assign bus.arready  = s_arready;
    assign bus.b        = s_b;
    assign bus.bvalid   = s_bvalid;
    assign bus.r        = s_r;
    assign bus.rvalid   = s_rvalid;
  end

  logic    m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
  axi_aw_t m_aw;
  axi_w_t  m_w;
  axi_ar_t m_ar;
  assign m_awvalid = awvalid_v[sel];
  assign m_wvalid  = wvalid_v[sel];
  assign m_arvalid = arvalid_v[sel];
  assign m_bready  = bready_v[sel];
  assign m_rready  = rready_v[sel];
  assign m_aw      = aw_v[sel];
  assign m_w       = w_v[sel];
  assign m_ar      = ar_v[sel];

  assign s_awready = rnd_mode ? rnd_aw : f_aw;
  assign s_wready  = rnd_mode ? rnd_w  : f_w;
  assign s_arready = rnd_mode ? rnd_ar : f_ar;

  always @(negedge clk) begin
    rnd_aw <= ($urandom_range(0, 3) != 0);
    rnd_w  <= ($urandom_range(0, 3) != 0);
    rnd_ar <= ($urandom_range(0, 3) != 0);
  end

  // Subordinate memory model with handshake history capture.
  logic [63:0] mem [8192];
  logic [31:0] aw_addr_h [HIST];
  logic [7:0]  aw_id_h   [HIST];
  logic [63:0] w_data_h  [HIST];
  logic [31:0] ar_addr_h [HIST];
  logic        aw_got, w_got;
  axi_aw_t     aw_l;
  logic [63:0] w_l;
  int          awc, wc, bc, arc, rc;

  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
      s_b <= '0; s_r <= '0; aw_l <= '0; w_l <= '0;
      awc <= 0; wc <= 0; bc <= 0; arc <= 0; rc <= 0;
    end else begin
      if (m_awvalid && s_awready) begin
        aw_got <= 1'b1;
        aw_l   <= m_aw;
        if (awc < HIST) begin
          aw_addr_h[awc] <= m_aw.addr;
          aw_id_h[awc]   <= m_aw.id;
        end
        awc <= awc + 1;
      end
      if (m_wvalid && s_wready) begin
        w_got <= 1'b1;
        w_l   <= m_w.data;
        if (wc < HIST) w_data_h[wc] <= m_w.data;
        wc <= wc + 1;
      end
      if (aw_got && w_got) begin
        mem[aw_l.addr[15:3]] <= w_l;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
        s_bvalid <= 1'b1;
        s_b.id   <= aw_l.id;
        s_b.resp <= (bc == inj_b) ? 2'd2 : 2'd0;
      end
      if (s_bvalid && m_bready) begin
        s_bvalid <= 1'b0;
        bc <= bc + 1;
      end
      if (m_arvalid && s_arready) begin
        if (arc < HIST) ar_addr_h[arc] <= m_ar.addr;
        arc      <= arc + 1;
        s_rvalid <= 1'b1;
        s_r.id   <= m_ar.id;
        s_r.resp <= 2'd0;
        s_r.data <= (arc == inj_r) ? 64'hDEAD : mem[m_ar.addr[15:3]];
      end
      if (s_rvalid && m_rready) begin
        s_rvalid <= 1'b0;
        rc <= rc + 1;
      end
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int bound);
    int c;
    c = 0;
    while (!done_v[k] && c < bound) begin
      tick();
      c++;
    end
    if (!done_v[k]) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_done dut%0d: done=0 after %0d cycles, required 1", k, bound);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = 3'($urandom);
      f_aw = 1'($urandom); f_w = 1'($urandom); f_ar = 1'($urandom);
      tick();
    end
    for (int k = 0; k < NDUT; k++) begin
      n_cmp++;
      if ({awvalid_v[k], wvalid_v[k], arvalid_v[k], bready_v[k], rready_v[k], done_v[k]} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl dut%0d: got %b%b%b%b%b%b required 000000", k,
                 awvalid_v[k], wvalid_v[k], arvalid_v[k], bready_v[k], rready_v[k], done_v[k]);
      end
      n_cmp++;
      if (txn_v[k] !== 32'd0 || err_v[k] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_cnt dut%0d: txn=%0d err=%0d required 0/0", k, txn_v[k], err_v[k]);
      end
      n_cmp++;
      if (aw_v[k] !== '0 || w_v[k] !== '0 || ar_v[k] !== '0) begin
        n_fail++;
        $display("FAIL reset_payload dut%0d: aw=%h w=%h ar=%h required 0", k, aw_v[k], w_v[k], ar_v[k]);
      end
    end
    start = '0;
    f_aw = 1'b1; f_w = 1'b1; f_ar = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (awc !== 0 || awvalid_v !== 3'b000) begin
      n_fail++;
      $display("FAIL no_aw_before_start: aw beats=%0d awvalid=%b required 0/000", awc, awvalid_v);
    end
  endtask

  task automatic test_single_pair();
    sel = 2'd0;
    do_reset();
    pulse_start(0);
    wait_done(0, 100);
    n_cmp++;
    if (awc !== 1 || aw_addr_h[0] !== exp_addr(0, 0) || aw_id_h[0] !== 8'(cid_of(0))) begin
      n_fail++;
      $display("FAIL single_aw: beats=%0d addr=%h id=%0d required 1/%h/%0d",
               awc, aw_addr_h[0], aw_id_h[0], exp_addr(0, 0), cid_of(0));
    end
    n_cmp++;
    if (w_data_h[0] !== exp_data(0, 0)) begin
      n_fail++;
      $display("FAIL single_w: data=%h required %h", w_data_h[0], exp_data(0, 0));
    end
    n_cmp++;
    if (ar_addr_h[0] !== exp_addr(0, 0) || rc !== 1) begin
      n_fail++;
      $display("FAIL single_ar_r: ar=%h r_beats=%0d required %h/1", ar_addr_h[0], rc, exp_addr(0, 0));
    end
    n_cmp++;
    if (txn_v[0] !== 32'd1 || err_v[0] !== 32'd0 || done_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_status: txn=%0d err=%0d done=%b required 1/0/1", txn_v[0], err_v[0], done_v[0]);
    end
    // A second start after DONE must be ignored.
    pulse_start(0);
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (awc !== 1 || done_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL done_sticky: aw beats=%0d done=%b required 1/1", awc, done_v[0]);
    end
  endtask

  task automatic test_backpressure();
    axi_aw_t aw0;
    sel = 2'd0;
    do_reset();
    f_aw = 1'b0; f_w = 1'b1; f_ar = 1'b1;
    pulse_start(0);
    aw0 = aw_v[0];
    n_cmp++;
    if (aw0.addr !== exp_addr(0, 0) || aw0.id !== 8'(cid_of(0)) || awvalid_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_aw_issue: addr=%h id=%0d valid=%b required %h/%0d/1",
               aw0.addr, aw0.id, awvalid_v[0], exp_addr(0, 0), cid_of(0));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (awvalid_v[0] !== 1'b1 || aw_v[0] !== aw0 || bready_v[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall%0d: awvalid=%b aw=%h bready=%b required 1/%h/0",
                 i, awvalid_v[0], aw_v[0], bready_v[0], aw0);
      end
    end
    n_cmp++;
    if (wvalid_v[0] !== 1'b0 || wc !== 1 || awc !== 0) begin
      n_fail++;
      $display("FAIL bp_w_first: wvalid=%b w beats=%0d aw beats=%0d required 0/1/0", wvalid_v[0], wc, awc);
    end
    f_aw = 1'b1;
    tick();
    n_cmp++;
    if (awc !== 1 || bready_v[0] !== 1'b1 || awvalid_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_wait_b: aw beats=%0d bready=%b awvalid=%b required 1/1/0", awc, bready_v[0], awvalid_v[0]);
    end
    wait_done(0, 100);
    n_cmp++;
    if (txn_v[0] !== 32'd1 || err_v[0] !== 32'd0) begin
      n_fail++;
      $display("FAIL bp_status: txn=%0d err=%0d required 1/0", txn_v[0], err_v[0]);
    end
  endtask

  task automatic test_error_inject();
    int exp_err;
    int bad;
    sel = 2'd2;
    do_reset();
    inj_b = 5; inj_r = 3;
    rnd_mode = 1'b1;
    pulse_start(2);
    wait_done(2, 3000);
    exp_err = 0;
    for (int i = 0; i < int'(tnb_of(2)); i++) if (i == inj_b || i == inj_r) exp_err++;
    n_cmp++;
    if (err_v[2] !== 32'(exp_err) || txn_v[2] !== 32'(tnb_of(2)) || done_v[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL err_status: err=%0d txn=%0d done=%b required %0d/%0d/1",
               err_v[2], txn_v[2], done_v[2], exp_err, tnb_of(2));
    end
    bad = 0;
    for (int i = 0; i < int'(tnb_of(2)); i++) begin
      if (aw_addr_h[i] !== exp_addr(2, i) || w_data_h[i] !== exp_data(2, i) ||
          ar_addr_h[i] !== exp_addr(2, i)) bad++;
    end
    n_cmp++;
    if (bad != 0 || awc != int'(tnb_of(2))) begin
      n_fail++;
      $display("FAIL err_beats: %0d bad pairs, aw beats=%0d required 0/%0d", bad, awc, tnb_of(2));
    end
    inj_b = -1; inj_r = -1;
    rnd_mode = 1'b0;
  endtask

  task automatic test_wrap();
    int bad;
    sel = 2'd1;
    do_reset();
    rnd_mode = 1'b1;
    pulse_start(1);
    wait_done(1, 20000);
    rnd_mode = 1'b0;
    n_cmp++;
    if (aw_addr_h[1024] !== exp_addr(1, 1024) || aw_addr_h[1025] !== exp_addr(1, 1025)) begin
      n_fail++;
      $display("FAIL wrap_addr: pair1024=%h pair1025=%h required %h/%h",
               aw_addr_h[1024], aw_addr_h[1025], exp_addr(1, 1024), exp_addr(1, 1025));
    end
    n_cmp++;
    if (w_data_h[1024] !== exp_data(1, 1024) || w_data_h[1025] !== exp_data(1, 1025)) begin
      n_fail++;
      $display("FAIL wrap_data: pair1024=%h pair1025=%h required %h/%h",
               w_data_h[1024], w_data_h[1025], exp_data(1, 1024), exp_data(1, 1025));
    end
    n_cmp++;
    if (err_v[1] !== 32'd0 || txn_v[1] !== 32'(tnb_of(1)) || done_v[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_status: err=%0d txn=%0d done=%b required 0/%0d/1", err_v[1], txn_v[1], done_v[1], tnb_of(1));
    end
    bad = 0;
    for (int i = 0; i < int'(tnb_of(1)); i++) begin
      if (aw_addr_h[i] !== exp_addr(1, i) || ar_addr_h[i] !== exp_addr(1, i) ||
          w_data_h[i] !== exp_data(1, i) || aw_id_h[i] !== 8'(cid_of(1))) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wrap_all_pairs: %0d bad pairs required 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    sel = 2'd1;
    do_reset();
    pulse_start(1);
    c = 0;
    while (!(arc == 11 && rready_v[1]) && c < 500) begin
      tick();
      c++;
    end
    n_cmp++;
    if (!(arc == 11 && rready_v[1]) || txn_v[1] !== 32'd10) begin
      n_fail++;
      $display("FAIL mid_reach_wait_r: ar beats=%0d rready=%b txn=%0d required 11/1/10", arc, rready_v[1], txn_v[1]);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({awvalid_v[1], wvalid_v[1], arvalid_v[1], bready_v[1], rready_v[1], done_v[1]} !== 6'b0 ||
        txn_v[1] !== 32'd0 || err_v[1] !== 32'd0 || aw_v[1] !== '0 || w_v[1] !== '0 || ar_v[1] !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_state: ctrl=%b%b%b%b%b%b txn=%0d err=%0d required all 0",
               awvalid_v[1], wvalid_v[1], arvalid_v[1], bready_v[1], rready_v[1], done_v[1], txn_v[1], err_v[1]);
    end
    rst = 1'b0;
    pulse_start(1);
    c = 0;
    while (awc < 1 && c < 50) begin
      tick();
      c++;
    end
    n_cmp++;
    if (awc < 1 || aw_addr_h[0] !== exp_addr(1, 0) || w_data_h[0] !== exp_data(1, 0)) begin
      n_fail++;
      $display("FAIL mid_restart: aw beats=%0d addr=%h data=%h required >=1/%h/%h",
               awc, aw_addr_h[0], w_data_h[0], exp_addr(1, 0), exp_data(1, 0));
    end
  endtask

  initial begin
    rst = 1'b1;
    start = '0;
    sel = 2'd0;
    f_aw = 1'b1; f_w = 1'b1; f_ar = 1'b1;
    rnd_mode = 1'b0;
    inj_b = -1; inj_r = -1;
    test_reset();
    test_single_pair();
    test_backpressure();
    test_error_inject();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
